// File: rtl/ds_scoreboard.sv
// Decode-stage register-hazard interlock: per-GPR pending-write counters,
// total in-flight occupancy, and a sticky protocol-violation flag.
module ds_scoreboard #(
   parameter int NREG  = 32,
   parameter int CNT_W = 2,
   parameter int OCC_W = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             ds_valid,
   input  logic [4:0]       ds_rs,
   input  logic             ds_rs_used,
   input  logic [4:0]       ds_rt,
   input  logic             ds_rt_used,
   input  logic             ds_gr_we,
   input  logic [4:0]       ds_dest,
   input  logic             ds_issue,
   input  logic             ws_retire,
   input  logic [4:0]       ws_dest,
   input  logic             flush,
   output logic             ds_stall,
   output logic [OCC_W-1:0] sb_occ,
   output logic             sb_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [OCC_W-1:0] OCC_MAX = '1;

   logic [CNT_W-1:0] pend_q [NREG];
   logic [CNT_W-1:0] pend_d [NREG];
   logic [OCC_W-1:0] occ_q, occ_d;
   logic             err_q, err_d;

   logic rs_hit, rt_hit, dest_full, occ_full;
   logic issue_req, issue_bad, issue_ovf, issue_inc;
   logic retire_req, retire_bad, retire_dec;

   // Stall reads registered state only; a retire releases the stall one cycle later.
   assign rs_hit    = ds_rs_used && (ds_rs != '0) && (pend_q[ds_rs] != '0);
   assign rt_hit    = ds_rt_used && (ds_rt != '0) && (pend_q[ds_rt] != '0);
   assign dest_full = ds_gr_we && (ds_dest != '0) && (pend_q[ds_dest] == CNT_MAX);
   assign occ_full  = (occ_q == OCC_MAX);
   assign ds_stall  = ds_valid && (rs_hit || rt_hit || dest_full || occ_full);

   assign issue_req  = ds_issue && ds_gr_we && (ds_dest != '0);
   assign issue_bad  = ds_issue && ds_stall;
   // Guards wrap-around when an issue arrives without ds_valid, where the stall cannot protect.
   assign issue_ovf  = issue_req && !issue_bad &&
                       ((pend_q[ds_dest] == CNT_MAX) || occ_full);
   assign issue_inc  = issue_req && !issue_bad && !issue_ovf;

   assign retire_req = ws_retire && (ws_dest != '0);
   assign retire_bad = retire_req && (pend_q[ws_dest] == '0);
   assign retire_dec = retire_req && !retire_bad;

   // NOTE: every always_comb output gets a default first so no path leaves a latch.
   always_comb begin
      pend_d = pend_q;
      occ_d  = occ_q;
      err_d  = err_q;
      if (flush) begin
         for (int i = 0; i < NREG; i++) begin
            pend_d[i] = '0;
         end
         occ_d = '0;
      end else begin
         err_d = err_q || issue_bad || issue_ovf || retire_bad;
         // Sequential blocking updates net to zero when issue and retire hit the same register.
         if (issue_inc) begin
            pend_d[ds_dest] = pend_d[ds_dest] + CNT_W'(1);
         end
         if (retire_dec) begin
            pend_d[ws_dest] = pend_d[ws_dest] - CNT_W'(1);
         end
         occ_d = occ_q + OCC_W'(issue_inc) - OCC_W'(retire_dec);
      end
      pend_d[0] = '0;
   end

   // NOTE: the counter array is ordinary flops, not RAM, so it is cleared by reset.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NREG; i++) begin
            pend_q[i] <= '0;
         end
         occ_q <= '0;
         err_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all flops sample together.
         pend_q <= pend_d;
         occ_q  <= occ_d;
         err_q  <= err_d;
      end
   end

   assign sb_occ = occ_q;
   assign sb_err = err_q;

endmodule
